// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer: next-PC select codes,
// sequencer states and the fixed instruction step.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer whose oldest entry is overwritten
// when full; push and pop together replace the top entry.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_idx_up;
    logic [PW-1:0]   w_wr_idx;

    // Depth is a power of two, so the index wraps on its own.
    assign w_idx_up = r_idx + 1'b1;
    assign w_wr_idx = pop ? r_idx : w_idx_up;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (push && !pop) begin
            r_idx <= w_idx_up;
            if (r_cnt != FULL_CNT)
                r_cnt <= r_cnt + 1'b1;
        end else if (pop && !push && r_cnt != '0) begin
            r_idx <= r_idx - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // NOTE: the entry array has no reset; validity is tracked by r_cnt alone,
    // which keeps the storage a plain register file / RAM.
    always_ff @(posedge clk) begin
        if (push)
            r_mem[w_wr_idx] <= din;
    end

    assign empty = (r_cnt == '0);
    assign top   = empty ? '0 : r_mem[r_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with exception/eret, halt and an optional
// return-address stack (built when PC_SEQ_RAS_EN is defined).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0180),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_wre,
    input  logic [1:0]      pc_src,
    input  logic            br_taken,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [XLEN-1:0] rs_val,
    input  logic            exc_req,
    input  logic            eret,
    input  logic            halt,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            halted,
    output logic            misalign
);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_epc_nxt;
    logic [XLEN-1:0] w_br_off;
    logic            w_src_upd;

    // Branch offset is in words: sign-extend and scale by four.
    assign w_br_off = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_VEC;
            r_pc4   <= RESET_VEC + STEP;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pc4   <= w_pc_nxt + STEP;
            r_epc   <= w_epc_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_src_upd   = 1'b0;
        if (r_state == ST_RUN) begin
            if (exc_req) begin
                w_epc_nxt = r_pc;
                w_pc_nxt  = EXC_VEC;
            end else if (pc_wre && halt) begin
                w_state_nxt = ST_HALT;
            end else if (pc_wre && eret) begin
                w_pc_nxt = r_epc;
            end else if (pc_wre) begin
                w_src_upd = 1'b1;
                case (pc_src_e'(pc_src))
                    PC_SEQ:  w_pc_nxt = r_pc4;
                    PC_BR:   w_pc_nxt = br_taken ? r_pc4 + w_br_off : r_pc4;
                    PC_J:    w_pc_nxt = {r_pc4[XLEN-1:28], addr26, 2'b00};
                    PC_JR:   w_pc_nxt = rs_val;
                    default: w_pc_nxt = r_pc4;
                endcase
            end
        end
    end

`ifdef PC_SEQ_RAS_EN
    // Calls push the return address, which is the pc4 of the calling cycle.
    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (w_src_upd && call),
        .pop   (w_src_upd && ret),
        .din   (r_pc4),
        .top   (ras_top),
        .empty (ras_empty)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic w_unused_ras;
    assign w_unused_ras = ^{call, ret, w_src_upd};
    assign ras_top      = '0;
    assign ras_empty    = 1'b1;
`endif

    assign pc_out   = r_pc;
    assign pc4      = r_pc4;
    assign epc      = r_epc;
    assign halted   = (r_state == ST_HALT);
    assign misalign = |r_pc[1:0];

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, program-counter width in bits (>= 28).
REQ-002 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0180, PC value loaded on exception.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 pc_wre  input  1  PC write enable; 0 = stall.
REQ-008 pc_src  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 register.
REQ-009 br_taken  input  1  branch condition; used only when pc_src=01.
REQ-010 imm16  input  16  branch offset, in words.
REQ-011 addr26  input  26  jump target field.
REQ-012 rs_val  input  XLEN  register jump target.
REQ-013 exc_req  input  1  exception request.
REQ-014 eret  input  1  return from exception.
REQ-015 halt  input  1  halt request.
REQ-016 call, ret  input  1 each  RAS push and pop strobes.
REQ-017 pc_out  output  XLEN  current PC.
REQ-018 pc4  output  XLEN  pc_out+4, registered.
REQ-019 epc  output  XLEN  saved exception PC.
REQ-020 ras_top  output  XLEN  RAS top entry (0 when empty).
REQ-021 ras_empty  output  1  RAS holds no entries.
REQ-022 halted  output  1  block is in HALT.
REQ-023 misalign  output  1  pc_out[1:0] != 0.

Function
REQ-024 States RUN and HALT; RUN with pc_wre=1 and halt=1 -> HALT; HALT exits only on reset.
REQ-025 In HALT, pc_out, pc4, epc and the RAS hold and halted=1; all inputs are ignored.
REQ-026 In RUN, exc_req=1 (pc_wre ignored) -> epc<=pc_out, pc_out<=EXC_VEC, next cycle.
REQ-027 Otherwise, with pc_wre=1, the priority is eret (pc_out<=epc), then pc_src.
REQ-028 Sequential: pc_out<=pc4; branch: pc_out<=pc4+(sext(imm16)<<2) if br_taken, else pc4.
REQ-029 Jump: pc_out<={pc4[XLEN-1:28], addr26, 2'b00}; register: pc_out<=rs_val.
REQ-030 All additions are modulo 2^XLEN; wrap-around is silent.
REQ-031 pc4 is updated in the same edge as pc_out and equals the new pc_out+4; one-cycle latency.
REQ-032 pc_wre=0 with no exc_req -> pc_out, pc4, epc and the RAS hold.
REQ-033 RAS operates only on cycles where pc_out updates through pc_src; a call pushes the old pc4.
REQ-034 When the RAS is full, a push overwrites the oldest entry and the count saturates at RAS_DEPTH.
REQ-035 A pop on an empty RAS is a no-op; call and ret together replace the top entry and the count is unchanged.
REQ-036 misalign is combinational from pc_out; no trap is raised internally.

Reset
REQ-037 reset=0 at a rising edge -> pc_out=RESET_VEC, pc4=RESET_VEC+4, epc=0, RAS empty, state RUN; this overrides all other inputs, including mid-HALT and mid-exception.

Configuration
REQ-038 Macro PC_SEQ_RAS_EN defined -> RAS built per REQ-033..035.
REQ-039 Macro PC_SEQ_RAS_EN undefined -> no RAS storage; ras_top=0, ras_empty=1, call and ret ignored.

Structure
REQ-040 Shared package pc_pkg holds the pc_src encodings (PC_SEQ, PC_BR, PC_J, PC_JR) and the state encoding.
REQ-041 The RAS is sub-module pc_ras (parameters XLEN, RAS_DEPTH; ports push, pop, din, top, empty).

Verification
REQ-042 Reset, then 3 cycles of pc_wre=1, pc_src=00 -> pc_out 0,4,8,C; pc4 one word ahead.
REQ-043 pc_out=0x10, pc_src=01, br_taken=1, imm16=0xFFFF -> pc_out=0x10; with br_taken=0 -> 0x14.
REQ-044 pc_out=0x40, exc_req=1 with pc_wre=0 -> pc_out=0x180, epc=0x40; then eret with pc_wre=1 -> pc_out=0x40.
REQ-045 With RAS enabled, 5 calls from pc4 values 0x4..0x14, then 5 rets -> ras_top 0x14,0x10,0xC,0x8 then ras_empty=1; the 0x4 entry is lost.
REQ-046 halt=1 with pc_wre=1 -> halted=1 and pc frozen for 10 cycles despite exc_req pulses; reset=0 -> pc_out=RESET_VEC, halted=0.
